// File: rtl/core_biu_arbiter_pkg.sv
// Shared definitions for the bus-interface arbiter: widths, arbitration modes,
// FSM state encoding and a small index helper.
package core_biu_arbiter_pkg;

    localparam int CORE_XLEN            = 32;
    localparam int CORE_LSU_WMASK_WIDTH = CORE_XLEN / 8;
    localparam int BIU_XLEN             = CORE_XLEN;
    localparam int BIU_WMASK_W          = CORE_LSU_WMASK_WIDTH;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } biu_state_e;

    // Increment a channel index, wrapping back to zero at the channel count.
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/core_biu_arbiter_if.sv
// Bundles for the requester side (several channels) and the single memory port.
// The arbiter is the slave of the requester bundle and the master of the memory bundle.
interface core_biu_ch_if #(
    parameter int NUM_CH  = 2,
    parameter int XLEN    = core_biu_arbiter_pkg::BIU_XLEN,
    parameter int WMASK_W = core_biu_arbiter_pkg::BIU_WMASK_W
);
    logic [NUM_CH-1:0]         ch_req_valid;
    logic [NUM_CH-1:0]         ch_req_ready;
    logic [NUM_CH*XLEN-1:0]    ch_req_addr;
    logic [NUM_CH*XLEN-1:0]    ch_req_wdata;
    logic [NUM_CH*WMASK_W-1:0] ch_req_wmask;
    logic [NUM_CH-1:0]         ch_req_wen;
    logic [NUM_CH-1:0]         ch_flush;
    logic [NUM_CH-1:0]         ch_rsp_valid;
    logic [XLEN-1:0]           ch_rsp_rdata;
    logic                      ch_rsp_err;

    modport master (
        output ch_req_valid, ch_req_addr, ch_req_wdata, ch_req_wmask, ch_req_wen, ch_flush,
        input  ch_req_ready, ch_rsp_valid, ch_rsp_rdata, ch_rsp_err
    );

    modport slave (
        input  ch_req_valid, ch_req_addr, ch_req_wdata, ch_req_wmask, ch_req_wen, ch_flush,
        output ch_req_ready, ch_rsp_valid, ch_rsp_rdata, ch_rsp_err
    );
endinterface

interface core_biu_mem_if #(
    parameter int XLEN    = core_biu_arbiter_pkg::BIU_XLEN,
    parameter int WMASK_W = core_biu_arbiter_pkg::BIU_WMASK_W
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic [XLEN-1:0]    mem_req_wdata;
    logic [WMASK_W-1:0] mem_req_wmask;
    logic               mem_req_wen;
    logic               mem_rsp_valid;
    logic [XLEN-1:0]    mem_rsp_rdata;
    logic               mem_rsp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/core_biu_arbiter_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting at ptr. The pointer register itself lives in the parent.
module core_biu_arb_pick
    import core_biu_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (ARB_MODE == ARB_RR) ? ((int'(ptr) + k) % NUM_CH) : k;
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/core_biu_arbiter.sv
// Multiplexes NUM_CH requesters onto one variable-latency memory port, routing each
// response back to its owner unless that owner flushed while the request was in flight.
module core_biu_arbiter
    import core_biu_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int XLEN     = BIU_XLEN,
    parameter int WMASK_W  = BIU_WMASK_W,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    core_biu_ch_if.slave    ch_bus,
    core_biu_mem_if.master  mem_bus,
    output logic            busy,
    output logic [CH_W-1:0] owner
);

    biu_state_e         state_q, state_d;
    logic [CH_W-1:0]    owner_q, owner_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic               drop_q, drop_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [WMASK_W-1:0] wmask_q, wmask_d;
    logic               wen_q, wen_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic [NUM_CH-1:0]  rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  pick_grant;
    logic [CH_W-1:0]    pick_idx;
    logic               pick_any;
    logic [NUM_CH-1:0]  req_ready;
    logic               owner_flush;

    // A channel being flushed this cycle must not start a new transaction.
    assign eligible    = ch_bus.ch_req_valid & ~ch_bus.ch_flush;
    assign owner_flush = ch_bus.ch_flush[owner_q];

    core_biu_arb_pick #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE),
        .CH_W     (CH_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        ptr_d           = ptr_q;
        drop_d          = drop_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        wen_d           = wen_q;
        mem_req_valid_d = mem_req_valid_q;
        rsp_valid_d     = '0;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
        req_ready       = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready       = pick_grant;
                    addr_d          = ch_bus.ch_req_addr[int'(pick_idx)*XLEN +: XLEN];
                    wdata_d         = ch_bus.ch_req_wdata[int'(pick_idx)*XLEN +: XLEN];
                    wmask_d         = ch_bus.ch_req_wmask[int'(pick_idx)*WMASK_W +: WMASK_W];
                    wen_d           = ch_bus.ch_req_wen[pick_idx];
                    owner_d         = pick_idx;
                    drop_d          = 1'b0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                    if (ARB_MODE == ARB_RR) begin
                        ptr_d = CH_W'(wrap_inc(int'(pick_idx), NUM_CH));
                    end
                end
            end
            // The memory request is never withdrawn; a flush only marks the answer for dropping.
            ST_ISSUE: begin
                if (owner_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_bus.mem_rsp_valid) begin
                    if (!(drop_q || owner_flush)) begin
                        rsp_valid_d[owner_q] = 1'b1;
                        rsp_rdata_d          = mem_bus.mem_rsp_rdata;
                        rsp_err_d            = mem_bus.mem_rsp_err;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mem_req_valid_d = 1'b0;
                state_d         = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= '0;
            ptr_q           <= '0;
            drop_q          <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            wen_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            ptr_q           <= ptr_d;
            drop_q          <= drop_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            wen_q           <= wen_d;
            mem_req_valid_q <= mem_req_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign ch_bus.ch_req_ready  = req_ready;
    assign ch_bus.ch_rsp_valid  = rsp_valid_q;
    assign ch_bus.ch_rsp_rdata  = rsp_rdata_q;
    assign ch_bus.ch_rsp_err    = rsp_err_q;
    assign mem_bus.mem_req_valid = mem_req_valid_q;
    assign mem_bus.mem_req_addr  = addr_q;
    assign mem_bus.mem_req_wdata = wdata_q;
    assign mem_bus.mem_req_wmask = wmask_q;
    assign mem_bus.mem_req_wen   = wen_q;
    assign busy  = (state_q != ST_IDLE);
    assign owner = owner_q;

    // A response with no transaction waiting for it is ignored by the FSM above.
    mem_rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n) mem_bus.mem_rsp_valid |-> (state_q == ST_WAIT)
    );

endmodule

// File: tb/tb_core_biu_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter and a 3-channel round-robin
// arbiter driven side by side with hand-computed expectations.
module tb_core_biu_arbiter;
    import core_biu_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_biu_ch_if  #(.NUM_CH(2), .XLEN(32), .WMASK_W(4)) ch2 ();
    core_biu_mem_if #(.XLEN(32), .WMASK_W(4))             mem2 ();
    core_biu_ch_if  #(.NUM_CH(3), .XLEN(32), .WMASK_W(4)) ch3 ();
    core_biu_mem_if #(.XLEN(32), .WMASK_W(4))             mem3 ();

    logic       busy2, busy3;
    logic [0:0] owner2;
    logic [1:0] owner3;

    core_biu_arbiter #(.NUM_CH(2), .XLEN(32), .WMASK_W(4), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .ch_bus(ch2), .mem_bus(mem2), .busy(busy2), .owner(owner2)
    );

    core_biu_arbiter #(.NUM_CH(3), .XLEN(32), .WMASK_W(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ch_bus(ch3), .mem_bus(mem3), .busy(busy3), .owner(owner3)
    );

    int total  = 0;
    int passed = 0;
    int p20 = 0, p21 = 0;
    int onehot_err = 0;

    // Count response pulses per channel and any multi-hot ready/valid vectors.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ch2.ch_rsp_valid[0]) p20++;
            if (ch2.ch_rsp_valid[1]) p21++;
            if ($countones(ch2.ch_req_ready) > 1 || $countones(ch2.ch_rsp_valid) > 1 ||
                $countones(ch3.ch_req_ready) > 1 || $countones(ch3.ch_rsp_valid) > 1)
                onehot_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch2.ch_req_valid = '0; ch2.ch_req_addr = '0; ch2.ch_req_wdata = '0;
        ch2.ch_req_wmask = '0; ch2.ch_req_wen = '0;  ch2.ch_flush = '0;
        ch3.ch_req_valid = '0; ch3.ch_req_addr = '0; ch3.ch_req_wdata = '0;
        ch3.ch_req_wmask = '0; ch3.ch_req_wen = '0;  ch3.ch_flush = '0;
        mem2.mem_req_ready = 1'b0; mem2.mem_rsp_valid = 1'b0; mem2.mem_rsp_rdata = '0; mem2.mem_rsp_err = 1'b0;
        mem3.mem_req_ready = 1'b0; mem3.mem_rsp_valid = 1'b0; mem3.mem_rsp_rdata = '0; mem3.mem_rsp_err = 1'b0;
    endtask

    task automatic drive2(input int ch, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic wen);
        ch2.ch_req_valid[ch]         = 1'b1;
        ch2.ch_req_addr[ch*32 +: 32] = addr;
        ch2.ch_req_wdata[ch*32 +: 32] = wdata;
        ch2.ch_req_wmask[ch*4 +: 4]  = wmask;
        ch2.ch_req_wen[ch]           = wen;
    endtask

    // From ISSUE: accept at once, answer on the following cycle; returns in the pulse cycle.
    task automatic mem2_finish(input logic [31:0] rdata, input logic err);
        mem2.mem_req_ready = 1'b1;
        tick();
        mem2.mem_req_ready = 1'b0;
        mem2.mem_rsp_valid = 1'b1;
        mem2.mem_rsp_rdata = rdata;
        mem2.mem_rsp_err   = err;
        tick();
        mem2.mem_rsp_valid = 1'b0;
    endtask

    task automatic mem3_finish(input logic [31:0] rdata);
        mem3.mem_req_ready = 1'b1;
        tick();
        mem3.mem_req_ready = 1'b0;
        mem3.mem_rsp_valid = 1'b1;
        mem3.mem_rsp_rdata = rdata;
        tick();
        mem3.mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (busy2 !== 1'b0) $display("[TB] FAIL reset_busy2: got %b expected 0", busy2); else passed++;
        total++; if (owner2 !== 1'b0) $display("[TB] FAIL reset_owner2: got %b expected 0", owner2); else passed++;
        total++; if (mem2.mem_req_valid !== 1'b0) $display("[TB] FAIL reset_memvalid2: got %b expected 0", mem2.mem_req_valid); else passed++;
        total++; if (mem2.mem_req_addr !== 32'h0) $display("[TB] FAIL reset_memaddr2: got %h expected 0", mem2.mem_req_addr); else passed++;
        total++; if (ch2.ch_rsp_valid !== 2'b00) $display("[TB] FAIL reset_rspvalid2: got %b expected 00", ch2.ch_rsp_valid); else passed++;
        total++; if (ch2.ch_rsp_rdata !== 32'h0) $display("[TB] FAIL reset_rdata2: got %h expected 0", ch2.ch_rsp_rdata); else passed++;
        total++; if (busy3 !== 1'b0) $display("[TB] FAIL reset_busy3: got %b expected 0", busy3); else passed++;
        total++; if (mem3.mem_req_valid !== 1'b0) $display("[TB] FAIL reset_memvalid3: got %b expected 0", mem3.mem_req_valid); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int b0, b1;
        b0 = p20; b1 = p21;
        drive2(1, 32'h8000_0004, 32'h0, 4'h0, 1'b0);
        #1;
        total++; if (ch2.ch_req_ready !== 2'b10) $display("[TB] FAIL single_ready: got %b expected 10", ch2.ch_req_ready); else passed++;
        tick();
        ch2.ch_req_valid = '0;
        total++; if (mem2.mem_req_valid !== 1'b1) $display("[TB] FAIL single_memvalid: got %b expected 1", mem2.mem_req_valid); else passed++;
        total++; if (mem2.mem_req_addr !== 32'h8000_0004) $display("[TB] FAIL single_addr: got %h expected 80000004", mem2.mem_req_addr); else passed++;
        total++; if (mem2.mem_req_wen !== 1'b0) $display("[TB] FAIL single_wen: got %b expected 0", mem2.mem_req_wen); else passed++;
        total++; if (busy2 !== 1'b1 || owner2 !== 1'b1) $display("[TB] FAIL single_busy_owner: got %b/%b expected 1/1", busy2, owner2); else passed++;
        tick();
        total++; if (mem2.mem_req_valid !== 1'b1) $display("[TB] FAIL single_hold: got %b expected 1", mem2.mem_req_valid); else passed++;
        mem2.mem_req_ready = 1'b1;
        tick();
        mem2.mem_req_ready = 1'b0;
        total++; if (mem2.mem_req_valid !== 1'b0) $display("[TB] FAIL single_wait_valid: got %b expected 0", mem2.mem_req_valid); else passed++;
        tick();
        tick();
        mem2.mem_rsp_valid = 1'b1;
        mem2.mem_rsp_rdata = 32'h0000_0013;
        mem2.mem_rsp_err   = 1'b0;
        tick();
        mem2.mem_rsp_valid = 1'b0;
        total++; if (ch2.ch_rsp_valid !== 2'b10) $display("[TB] FAIL single_rspvalid: got %b expected 10", ch2.ch_rsp_valid); else passed++;
        total++; if (ch2.ch_rsp_rdata !== 32'h13 || ch2.ch_rsp_err !== 1'b0) $display("[TB] FAIL single_rdata_err: got %h/%b expected 13/0", ch2.ch_rsp_rdata, ch2.ch_rsp_err); else passed++;
        total++; if (busy2 !== 1'b0) $display("[TB] FAIL single_idle: got %b expected 0", busy2); else passed++;
        tick();
        total++; if (ch2.ch_rsp_valid !== 2'b00) $display("[TB] FAIL single_pulse_end: got %b expected 00", ch2.ch_rsp_valid); else passed++;
        total++; if (p21 - b1 !== 1 || p20 - b0 !== 0) $display("[TB] FAIL single_pulse_count: got ch1=%0d ch0=%0d expected 1/0", p21 - b1, p20 - b0); else passed++;
    endtask

    task automatic test_simultaneous();
        drive2(0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
        drive2(1, 32'h8000_2000, 32'h0, 4'h0, 1'b0);
        #1;
        total++; if (ch2.ch_req_ready !== 2'b01) $display("[TB] FAIL simul_ready0: got %b expected 01", ch2.ch_req_ready); else passed++;
        tick();
        ch2.ch_req_valid[0] = 1'b0;
        #1;
        total++; if (owner2 !== 1'b0) $display("[TB] FAIL simul_owner0: got %b expected 0", owner2); else passed++;
        total++; if (mem2.mem_req_wen !== 1'b1 || mem2.mem_req_wmask !== 4'hF) $display("[TB] FAIL simul_wen_mask: got %b/%h expected 1/f", mem2.mem_req_wen, mem2.mem_req_wmask); else passed++;
        total++; if (mem2.mem_req_addr !== 32'h8000_1000 || mem2.mem_req_wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL simul_addr_data: got %h/%h expected 80001000/deadbeef", mem2.mem_req_addr, mem2.mem_req_wdata); else passed++;
        total++; if (ch2.ch_req_ready !== 2'b00) $display("[TB] FAIL simul_noready_busy: got %b expected 00", ch2.ch_req_ready); else passed++;
        mem2_finish(32'h0, 1'b0);
        #1;
        total++; if (ch2.ch_rsp_valid !== 2'b01) $display("[TB] FAIL simul_rsp0: got %b expected 01", ch2.ch_rsp_valid); else passed++;
        total++; if (ch2.ch_req_ready !== 2'b10) $display("[TB] FAIL simul_ready1_in_pulse: got %b expected 10", ch2.ch_req_ready); else passed++;
        tick();
        ch2.ch_req_valid[1] = 1'b0;
        total++; if (owner2 !== 1'b1 || mem2.mem_req_addr !== 32'h8000_2000 || mem2.mem_req_wen !== 1'b0) $display("[TB] FAIL simul_ch1_issue: got %b/%h/%b expected 1/80002000/0", owner2, mem2.mem_req_addr, mem2.mem_req_wen); else passed++;
        mem2_finish(32'h0000_0055, 1'b0);
        total++; if (ch2.ch_rsp_valid !== 2'b10 || ch2.ch_rsp_rdata !== 32'h55) $display("[TB] FAIL simul_rsp1: got %b/%h expected 10/55", ch2.ch_rsp_valid, ch2.ch_rsp_rdata); else passed++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_oh;
        logic [1:0]  exp_ch;
        logic [31:0] exp_addr;
        for (int c = 0; c < 3; c++) begin
            ch3.ch_req_addr[c*32 +: 32] = 32'h9000_0000 + 32'(c * 16);
        end
        ch3.ch_req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_ch   = 2'(i % 3);
            exp_oh   = 3'b001 << exp_ch;
            exp_addr = 32'h9000_0000 + 32'(exp_ch) * 32'd16;
            #1;
            total++; if (ch3.ch_req_ready !== exp_oh) $display("[TB] FAIL rr_ready_%0d: got %b expected %b", i, ch3.ch_req_ready, exp_oh); else passed++;
            tick();
            total++; if (owner3 !== exp_ch || mem3.mem_req_addr !== exp_addr) $display("[TB] FAIL rr_owner_%0d: got %0d/%h expected %0d/%h", i, owner3, mem3.mem_req_addr, exp_ch, exp_addr); else passed++;
            mem3_finish(32'(i + 1));
            total++; if (ch3.ch_rsp_valid !== exp_oh || ch3.ch_rsp_rdata !== 32'(i + 1)) $display("[TB] FAIL rr_rsp_%0d: got %b/%h expected %b/%h", i, ch3.ch_rsp_valid, ch3.ch_rsp_rdata, exp_oh, 32'(i + 1)); else passed++;
        end
        ch3.ch_req_valid = '0;
        tick();
        total++; if (busy3 !== 1'b0) $display("[TB] FAIL rr_idle_end: got %b expected 0", busy3); else passed++;
    endtask

    task automatic test_flush_wait();
        int b1;
        b1 = p21;
        drive2(1, 32'h8000_0010, 32'h0, 4'h0, 1'b0);
        ch2.ch_flush[1] = 1'b1;
        #1;
        total++; if (ch2.ch_req_ready !== 2'b00) $display("[TB] FAIL flush_mask_ready: got %b expected 00", ch2.ch_req_ready); else passed++;
        tick();
        total++; if (busy2 !== 1'b0) $display("[TB] FAIL flush_mask_busy: got %b expected 0", busy2); else passed++;
        ch2.ch_flush = '0;
        #1;
        total++; if (ch2.ch_req_ready !== 2'b10) $display("[TB] FAIL flush_unmask_ready: got %b expected 10", ch2.ch_req_ready); else passed++;
        tick();
        ch2.ch_req_valid = '0;
        mem2.mem_req_ready = 1'b1;
        tick();
        mem2.mem_req_ready = 1'b0;
        ch2.ch_flush[1] = 1'b1;
        tick();
        ch2.ch_flush = '0;
        tick();
        mem2.mem_rsp_valid = 1'b1;
        mem2.mem_rsp_rdata = 32'h0000_00AA;
        tick();
        mem2.mem_rsp_valid = 1'b0;
        total++; if (ch2.ch_rsp_valid !== 2'b00 || busy2 !== 1'b0) $display("[TB] FAIL flush_wait_drop: got %b/%b expected 00/0", ch2.ch_rsp_valid, busy2); else passed++;
        drive2(1, 32'h8000_0014, 32'h0, 4'h0, 1'b0);
        #1;
        total++; if (ch2.ch_req_ready !== 2'b10) $display("[TB] FAIL flush_next_ready: got %b expected 10", ch2.ch_req_ready); else passed++;
        tick();
        ch2.ch_req_valid = '0;
        mem2_finish(32'h0000_0077, 1'b0);
        total++; if (ch2.ch_rsp_valid !== 2'b10 || ch2.ch_rsp_rdata !== 32'h77) $display("[TB] FAIL flush_next_rsp: got %b/%h expected 10/77", ch2.ch_rsp_valid, ch2.ch_rsp_rdata); else passed++;
        tick();
        total++; if (p21 - b1 !== 1) $display("[TB] FAIL flush_pulse_count: got %0d expected 1", p21 - b1); else passed++;
    endtask

    task automatic test_flush_issue();
        drive2(1, 32'h8000_0020, 32'h0, 4'h0, 1'b0);
        tick();
        ch2.ch_req_valid = '0;
        ch2.ch_flush[1] = 1'b1;
        tick();
        ch2.ch_flush = '0;
        total++; if (mem2.mem_req_valid !== 1'b1 || mem2.mem_req_addr !== 32'h8000_0020) $display("[TB] FAIL issue_flush_hold1: got %b/%h expected 1/80000020", mem2.mem_req_valid, mem2.mem_req_addr); else passed++;
        tick();
        total++; if (mem2.mem_req_valid !== 1'b1 || mem2.mem_req_addr !== 32'h8000_0020) $display("[TB] FAIL issue_flush_hold2: got %b/%h expected 1/80000020", mem2.mem_req_valid, mem2.mem_req_addr); else passed++;
        mem2_finish(32'h0000_00BB, 1'b0);
        total++; if (ch2.ch_rsp_valid !== 2'b00) $display("[TB] FAIL issue_flush_drop: got %b expected 00", ch2.ch_rsp_valid); else passed++;
        tick();
    endtask

    task automatic test_flush_coincident();
        drive2(1, 32'h8000_0030, 32'h0, 4'h0, 1'b0);
        tick();
        ch2.ch_req_valid = '0;
        mem2.mem_req_ready = 1'b1;
        tick();
        mem2.mem_req_ready = 1'b0;
        mem2.mem_rsp_valid = 1'b1;
        mem2.mem_rsp_rdata = 32'h0000_00C0;
        ch2.ch_flush[1] = 1'b1;
        tick();
        mem2.mem_rsp_valid = 1'b0;
        ch2.ch_flush = '0;
        total++; if (ch2.ch_rsp_valid !== 2'b00 || busy2 !== 1'b0) $display("[TB] FAIL coincident_drop: got %b/%b expected 00/0", ch2.ch_rsp_valid, busy2); else passed++;
        drive2(1, 32'h8000_0034, 32'h0, 4'h0, 1'b0);
        tick();
        ch2.ch_req_valid = '0;
        mem2.mem_req_ready = 1'b1;
        tick();
        mem2.mem_req_ready = 1'b0;
        ch2.ch_flush[0] = 1'b1;
        tick();
        mem2.mem_rsp_valid = 1'b1;
        mem2.mem_rsp_rdata = 32'h0000_00CC;
        tick();
        mem2.mem_rsp_valid = 1'b0;
        ch2.ch_flush = '0;
        total++; if (ch2.ch_rsp_valid !== 2'b10 || ch2.ch_rsp_rdata !== 32'hCC) $display("[TB] FAIL nonowner_flush: got %b/%h expected 10/cc", ch2.ch_rsp_valid, ch2.ch_rsp_rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive2(0, 32'h8000_0040, 32'h0, 4'h0, 1'b0);
        tick();
        ch2.ch_req_valid = '0;
        mem2.mem_req_ready = 1'b1;
        tick();
        mem2.mem_req_ready = 1'b0;
        total++; if (busy2 !== 1'b1) $display("[TB] FAIL rstwait_busy_before: got %b expected 1", busy2); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (busy2 !== 1'b0 || mem2.mem_req_valid !== 1'b0 || owner2 !== 1'b0) $display("[TB] FAIL rstwait_ctrl: got %b/%b/%b expected 0/0/0", busy2, mem2.mem_req_valid, owner2); else passed++;
        total++; if (mem2.mem_req_addr !== 32'h0 || ch2.ch_rsp_rdata !== 32'h0 || ch2.ch_rsp_valid !== 2'b00) $display("[TB] FAIL rstwait_data: got %h/%h/%b expected 0/0/00", mem2.mem_req_addr, ch2.ch_rsp_rdata, ch2.ch_rsp_valid); else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive2(0, 32'h8000_0044, 32'h0, 4'h0, 1'b0);
        #1;
        total++; if (ch2.ch_req_ready !== 2'b01) $display("[TB] FAIL rstwait_ready: got %b expected 01", ch2.ch_req_ready); else passed++;
        tick();
        ch2.ch_req_valid = '0;
        mem2_finish(32'h0000_00E0, 1'b1);
        total++; if (ch2.ch_rsp_valid !== 2'b01 || ch2.ch_rsp_err !== 1'b1 || ch2.ch_rsp_rdata !== 32'hE0) $display("[TB] FAIL rstwait_err: got %b/%b/%h expected 01/1/e0", ch2.ch_rsp_valid, ch2.ch_rsp_err, ch2.ch_rsp_rdata); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_flush_wait();
        test_flush_issue();
        test_flush_coincident();
        test_reset_mid_wait();
        total++; if (onehot_err !== 0) $display("[TB] FAIL onehot: got %0d multi-hot cycles expected 0", onehot_err); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/core_biu_arbiter.md
Name: core_biu_arbiter

Overview:
- Parametrised bus-interface arbiter. It replaces the direct combinational IFU-ROM and LSU-PMEM hookup.
- Multiplexes NUM_CH requesters onto one variable-latency memory port using valid/ready request handshakes and responses with per-channel routing.
- Supports fixed-priority or round-robin arbitration.
- A per-channel flush from the commit stage causes an in-flight response to be discarded, never delivered.

Parameters:
- NUM_CH, 2, number of requesting channels (ch0 = LSU, ch1 = IFU by convention); range 2..8
- XLEN, 32, address and data width
- WMASK_W, 4, write-byte-mask width (XLEN/8)
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- CH_W, $clog2(NUM_CH), channel index width (derived; do not override)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ch_req_valid  in  NUM_CH  per-channel request valid
- ch_req_ready  out  NUM_CH  per-channel request accepted (one-hot or zero)
- ch_req_addr  in  NUM_CH*XLEN  flattened addresses, channel i at [i*XLEN +: XLEN]
- ch_req_wdata  in  NUM_CH*XLEN  flattened write data
- ch_req_wmask  in  NUM_CH*WMASK_W  flattened byte masks
- ch_req_wen  in  NUM_CH  1 = write, 0 = read
- ch_flush  in  NUM_CH  per-channel flush (pipeline flush request)
- ch_rsp_valid  out  NUM_CH  per-channel response valid, one-cycle pulse; always accepted
- ch_rsp_rdata  out  XLEN  shared response data, qualified by ch_rsp_valid
- ch_rsp_err  out  1  response error, qualified by ch_rsp_valid
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  memory address
- mem_req_wdata  out  XLEN  memory write data
- mem_req_wmask  out  WMASK_W  memory write mask
- mem_req_wen  out  1  memory write enable
- mem_rsp_valid  in  1  memory response valid (exactly one per accepted request)
- mem_rsp_rdata  in  XLEN  memory read data
- mem_rsp_err  in  1  memory error
- busy  out  1  transaction in progress (state != IDLE)
- owner  out  CH_W  channel owning the current transaction

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs and latched request registers 0.
  - Round-robin pointer 0, drop flag 0.
  - A transaction in flight is abandoned; the memory side shares rst_n.
- States:
  - IDLE:
    - Eligible set = ch_req_valid & ~ch_flush.
    - If nonzero: pick winner; ch_req_ready[winner]=1 combinationally this cycle; latch addr/wdata/wmask/wen/owner; drop=0; go to ISSUE.
  - ISSUE:
    - mem_req_valid=1 with latched fields, held stable until mem_req_ready.
    - On mem_req_ready go to WAIT.
    - Never withdrawn, even on flush.
  - WAIT:
    - On mem_rsp_valid: register rdata/err.
    - Next cycle, ch_rsp_valid[owner]=1 unless drop (drop takes the flush of the same cycle into account).
    - Go to IDLE.
- Latency: accept cycle T; mem_req_valid from T+1; response pulse one cycle after mem_rsp_valid. Minimum transaction 4 cycles (mem_req_ready and mem_rsp_valid at earliest).
- Response pulse cycle coincides with IDLE, so a new grant may occur in the same cycle as a response pulse.
- Flush:
  - ch_flush[owner] in ISSUE or WAIT, including the mem_rsp_valid cycle, sets drop.
  - Flush of a non-owner channel has no effect.
  - A flushed channel is masked from arbitration in that cycle only.
- Arbitration:
  - ARB_MODE=0: lowest eligible index.
  - ARB_MODE=1: first eligible index at or after the pointer, wrapping modulo NUM_CH. On a grant the pointer becomes (winner+1) mod NUM_CH, so NUM_CH-1 wraps to 0.
- mem_rsp_valid outside WAIT is a protocol error: ignored and never forwarded. An assertion flags it in simulation.
- ch_rsp_rdata and ch_rsp_err hold their last value between pulses.
- At most one ch_req_ready bit and one ch_rsp_valid bit are high per cycle.

Decomposition:
- Shared package/defines:
  - ARB_MODE encodings (ARB_FIXED=0, ARB_RR=1)
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2)
  - BIU width macros aligned with CORE_XLEN and CORE_LSU_WMASK_WIDTH
- Sub-module core_biu_arb_pick:
  - NUM_CH-wide picker taking eligible and pointer, returning one-hot grant and index.
  - Pure combinational.
  - Pointer register stays in the parent.

Test Plan:
- Single read, ch1, addr 0x8000_0004; memory ready after 2 cycles, rsp 3 cycles later with rdata 0x0000_0013 -> exactly one ch_rsp_valid[1] pulse with rdata 0x13 and err=0; ch_rsp_valid[0] never high.
- Simultaneous requests, ch0 write 0x8000_1000 data 0xDEADBEEF mask 0xF and ch1 read, ARB_MODE=0 -> ch0 granted first with mem_req_wen=1 and wmask=0xF; ch1 granted in the cycle of ch0's response pulse.
- ARB_MODE=1, NUM_CH=3, all channels continuously valid for 6 transactions -> grant order 0,1,2,0,1,2; pointer wraps from 2 to 0.
- ch1 read in WAIT, ch_flush[1] pulsed, then mem_rsp_valid -> no ch_rsp_valid pulse; busy drops and the next request is granted normally. Repeat with flush in ISSUE while mem_req_ready=0 -> mem_req_valid stays high with stable fields until ready.
- Flush coincident with mem_rsp_valid -> response dropped. Flush on ch0 while ch1 owns -> ch1 response delivered.
- rst_n asserted mid-WAIT -> all outputs 0 immediately; after release a new ch0 request completes with mem_rsp_err=1 forwarded as ch_rsp_err=1.
